// File: rtl/data_mem_arbiter.sv
// Two-master round-robin arbiter for a single shared data memory port.
// One transaction in flight at a time; a stalled memory is aborted after TIMEOUT_CYCLES.
module data_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  input  logic                  m0_we_i,
  input  logic [BE_WIDTH-1:0]   m0_be_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  input  logic                  m1_we_i,
  input  logic [BE_WIDTH-1:0]   m1_be_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  slv_req_o,
  output logic [ADDR_WIDTH-1:0] slv_addr_o,
  output logic                  slv_we_o,
  output logic [BE_WIDTH-1:0]   slv_be_o,
  output logic [DATA_WIDTH-1:0] slv_wdata_o,
  input  logic                  slv_gnt_i,
  input  logic                  slv_rvalid_i,
  input  logic [DATA_WIDTH-1:0] slv_rdata_i,
  output logic                  err_o,
  output logic                  dbg_state_o
);

  // Handshake: a master holds req and payload until it sees gnt; gnt (and rvalid for
  // reads) arrive in the cycle the memory grants, one cycle after slv_req_o was issued.

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t                state_q, state_d;
  logic                  owner_q, last_q;
  logic [7:0]            tmo_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic winner, any_req, complete, abort;

  always_comb begin
    state_d     = state_q;
    any_req     = m0_req_i | m1_req_i;
    // Lone requester wins; on a tie the master that did not go last wins.
    winner      = m1_req_i & (~m0_req_i | ~last_q);
    complete    = 1'b0;
    abort       = 1'b0;
    slv_req_o   = 1'b0;
    slv_addr_o  = addr_q;
    slv_we_o    = we_q;
    slv_be_o    = be_q;
    slv_wdata_o = wdata_q;
    m0_gnt_o    = 1'b0;
    m0_rvalid_o = 1'b0;
    m0_rdata_o  = slv_rdata_i;
    m1_gnt_o    = 1'b0;
    m1_rvalid_o = 1'b0;
    m1_rdata_o  = slv_rdata_i;
    err_o       = 1'b0;
    dbg_state_o = (state_q == ST_WAIT);

    if (state_q == ST_IDLE) begin
      if (any_req) begin
        slv_req_o   = 1'b1;
        slv_addr_o  = winner ? m1_addr_i  : m0_addr_i;
        slv_we_o    = winner ? m1_we_i    : m0_we_i;
        slv_be_o    = winner ? m1_be_i    : m0_be_i;
        slv_wdata_o = winner ? m1_wdata_i : m0_wdata_i;
        state_d     = ST_WAIT;
      end
    end else begin
      // A grant arriving in the timeout cycle still counts as a normal completion.
      complete = slv_gnt_i;
      abort    = ~slv_gnt_i & (tmo_q == TMO_LIMIT);
      err_o    = abort;
      if (complete | abort) state_d = ST_IDLE;
      if (owner_q) begin
        m1_gnt_o    = complete | abort;
        m1_rvalid_o = abort ? ~we_q : slv_rvalid_i;
        if (abort) m1_rdata_o = '0;
      end else begin
        m0_gnt_o    = complete | abort;
        m0_rvalid_o = abort ? ~we_q : slv_rvalid_i;
        if (abort) m0_rdata_o = '0;
      end
    end

    // Reset silences every output immediately, without waiting for a clock.
    if (rst_i) begin
      slv_req_o   = 1'b0;
      slv_addr_o  = '0;
      slv_we_o    = 1'b0;
      slv_be_o    = '0;
      slv_wdata_o = '0;
      m0_gnt_o    = 1'b0;
      m0_rvalid_o = 1'b0;
      m0_rdata_o  = '0;
      m1_gnt_o    = 1'b0;
      m1_rvalid_o = 1'b0;
      m1_rdata_o  = '0;
      err_o       = 1'b0;
      dbg_state_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      tmo_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        if (any_req) begin
          owner_q <= winner;
          tmo_q   <= '0;
          addr_q  <= slv_addr_o;
          we_q    <= slv_we_o;
          be_q    <= slv_be_o;
          wdata_q <= slv_wdata_o;
        end
      end else if (complete | abort) begin
        last_q <= owner_q;
      end else begin
        tmo_q <= tmo_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_data_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int TMO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          mreq[2];
  logic [AW-1:0] maddr[2];
  logic [DW-1:0] mwdata[2];
  logic          mwe[2];
  logic [BW-1:0] mbe[2];
  logic          m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          slv_req_o, slv_we_o;
  logic [AW-1:0] slv_addr_o;
  logic [BW-1:0] slv_be_o;
  logic [DW-1:0] slv_wdata_o;
  logic          slv_gnt, slv_rvalid;
  logic [DW-1:0] slv_rdata;
  logic          err_o, dbg_state_o;

  data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(mreq[0]), .m0_addr_i(maddr[0]), .m0_wdata_i(mwdata[0]), .m0_we_i(mwe[0]),
    .m0_be_i(mbe[0]), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(mreq[1]), .m1_addr_i(maddr[1]), .m1_wdata_i(mwdata[1]), .m1_we_i(mwe[1]),
    .m1_be_i(mbe[1]), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .slv_req_o(slv_req_o), .slv_addr_o(slv_addr_o), .slv_we_o(slv_we_o), .slv_be_o(slv_be_o),
    .slv_wdata_o(slv_wdata_o), .slv_gnt_i(slv_gnt), .slv_rvalid_i(slv_rvalid),
    .slv_rdata_i(slv_rdata), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: one outstanding transaction, its owner, its payload and
  // how many ungranted cycles it has waited; round-robin remembers the last finisher.
  bit            m_busy  = 1'b0;
  bit            m_owner = 1'b0;
  bit            m_last  = 1'b1;
  int            m_tmo   = 0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_we    = 1'b0;
  logic [BW-1:0] m_be    = '0;
  bit            got_g[2];
  bit            new_issue = 1'b0;

  always @(negedge clk) begin
    logic w, done, abrt, e_g, e_rv;
    logic [DW-1:0] e_rd;
    got_g[0] = 1'b0;
    got_g[1] = 1'b0;
    if (rst) begin
      check("m_rst_flags", {slv_req_o, slv_we_o, slv_be_o, m0_gnt_o, m0_rvalid_o,
                            m1_gnt_o, m1_rvalid_o, err_o, dbg_state_o}, 64'd0);
      check("m_rst_slv", {slv_addr_o, slv_wdata_o}, 64'd0);
      check("m_rst_rdata", {m0_rdata_o, m1_rdata_o}, 64'd0);
      m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_tmo = 0;
    end else if (!m_busy) begin
      check("m_idle_flags", {m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o, err_o, dbg_state_o}, 64'd0);
      check("m_idle_rdata", {m0_rdata_o, m1_rdata_o}, {slv_rdata, slv_rdata});
      if (mreq[0] || mreq[1]) begin
        w = (mreq[0] && mreq[1]) ? !m_last : mreq[1];
        check("m_issue_req", slv_req_o, 64'd1);
        check("m_issue_addr", slv_addr_o, maddr[w]);
        check("m_issue_ctl", {slv_we_o, slv_be_o}, {mwe[w], mbe[w]});
        check("m_issue_wdata", slv_wdata_o, mwdata[w]);
        m_busy = 1'b1; m_owner = w; m_tmo = 0;
        m_addr = maddr[w]; m_we = mwe[w]; m_be = mbe[w]; m_wdata = mwdata[w];
        new_issue = 1'b1;
      end else begin
        check("m_idle_req", slv_req_o, 64'd0);
      end
    end else begin
      done = slv_gnt;
      abrt = !slv_gnt && (m_tmo == TMO);
      e_g  = done || abrt;
      e_rv = abrt ? !m_we : slv_rvalid;
      e_rd = abrt ? '0 : slv_rdata;
      check("m_wait_ctl", {slv_req_o, slv_we_o, slv_be_o, dbg_state_o}, {1'b0, m_we, m_be, 1'b1});
      check("m_wait_payload", {slv_addr_o, slv_wdata_o}, {m_addr, m_wdata});
      if (m_owner) begin
        check("m_m0_resp", {m0_gnt_o, m0_rvalid_o, m0_rdata_o}, {2'b00, slv_rdata});
        check("m_m1_resp", {m1_gnt_o, m1_rvalid_o, m1_rdata_o}, {e_g, e_rv, e_rd});
      end else begin
        check("m_m0_resp", {m0_gnt_o, m0_rvalid_o, m0_rdata_o}, {e_g, e_rv, e_rd});
        check("m_m1_resp", {m1_gnt_o, m1_rvalid_o, m1_rdata_o}, {2'b00, slv_rdata});
      end
      check("m_err", err_o, {63'd0, abrt});
      got_g[m_owner] = e_g;
      if (e_g) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end else begin
        m_tmo++;
      end
    end
  end

  int mem_delay = 1;
  int mem_age   = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      mreq[i] = 1'b0; maddr[i] = '0; mwdata[i] = '0; mwe[i] = 1'b0; mbe[i] = '0;
    end
    slv_gnt = 1'b0; slv_rvalid = 1'b0; slv_rdata = '0;

    // Reset holds outputs low even with a request pending.
    mreq[0] = 1'b1; maddr[0] = 32'h44;
    @(negedge clk);
    check("rst_slv_req", slv_req_o, 64'd0);
    check("rst_dbg_state", dbg_state_o, 64'd0);
    mreq[0] = 1'b0;
    step(); rst = 1'b0;

    // m0 read at 0x10 returning 0xDEADBEEF.
    step(); mreq[0] = 1'b1; maddr[0] = 32'h10; mwe[0] = 1'b0; mbe[0] = 4'hF;
    @(negedge clk);
    check("d_rd_issue", {slv_req_o, slv_we_o}, 64'b10);
    check("d_rd_addr", slv_addr_o, 64'h10);
    step(); slv_gnt = 1'b1; slv_rvalid = 1'b1; slv_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("d_rd_gnt", {m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o}, 64'b1100);
    check("d_rd_data", m0_rdata_o, 64'hDEADBEEF);
    step(); mreq[0] = 1'b0; slv_gnt = 1'b0; slv_rvalid = 1'b0;
    @(negedge clk);
    check("d_rd_after", {m0_gnt_o, dbg_state_o}, 64'd0);

    // m1 write at 0x20, be 0011.
    step(); mreq[1] = 1'b1; maddr[1] = 32'h20; mwe[1] = 1'b1; mbe[1] = 4'b0011; mwdata[1] = 32'h12345678;
    @(negedge clk);
    check("d_wr_issue", {slv_req_o, slv_we_o, slv_be_o}, 64'b1_1_0011);
    check("d_wr_addr", slv_addr_o, 64'h20);
    check("d_wr_wdata", slv_wdata_o, 64'h12345678);
    step(); slv_gnt = 1'b1;
    @(negedge clk);
    check("d_wr_gnt", {m1_gnt_o, m1_rvalid_o, m0_gnt_o}, 64'b100);
    step(); mreq[1] = 1'b0; slv_gnt = 1'b0;
    @(negedge clk);
    check("d_wr_no_rvalid", m1_rvalid_o, 64'd0);

    // m0 read with a memory that never grants.
    step(); mreq[0] = 1'b1; maddr[0] = 32'h30; mwe[0] = 1'b0; slv_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    check("d_tmo_issue", slv_req_o, 64'd1);
    for (int k = 1; k <= TMO; k++) begin
      step();
      @(negedge clk);
      check("d_tmo_waiting", {m0_gnt_o, err_o, dbg_state_o}, 64'b001);
    end
    step();
    @(negedge clk);
    check("d_tmo_abort", {m0_gnt_o, m0_rvalid_o, err_o}, 64'b111);
    check("d_tmo_rdata", m0_rdata_o, 64'd0);
    check("d_tmo_other_rdata", m1_rdata_o, 64'hA5A5A5A5);
    step(); mreq[0] = 1'b0;
    @(negedge clk);
    check("d_tmo_after", {m0_gnt_o, m0_rvalid_o, err_o, dbg_state_o}, 64'd0);

    // Grant arrives in the very cycle the timeout would fire.
    step(); mreq[1] = 1'b1; maddr[1] = 32'h40; mwe[1] = 1'b0;
    repeat (TMO) step();
    step(); slv_gnt = 1'b1; slv_rvalid = 1'b1; slv_rdata = 32'h0BADF00D;
    @(negedge clk);
    check("d_race_resp", {m1_gnt_o, m1_rvalid_o, err_o}, 64'b110);
    check("d_race_rdata", m1_rdata_o, 64'h0BADF00D);
    step(); mreq[1] = 1'b0; slv_gnt = 1'b0; slv_rvalid = 1'b0;

    // Reset during WAIT: m0 finishes once (last = m0), reissues, then reset hits.
    step(); mreq[0] = 1'b1; maddr[0] = 32'h50; mwe[0] = 1'b0;
    step(); slv_gnt = 1'b1;
    step(); slv_gnt = 1'b0;
    step(); rst = 1'b1; slv_gnt = 1'b1; slv_rvalid = 1'b1; mreq[1] = 1'b1; maddr[1] = 32'h60;
    @(negedge clk);
    check("d_rst_wait_outs", {slv_req_o, m0_gnt_o, m0_rvalid_o, m1_gnt_o, err_o, dbg_state_o}, 64'd0);
    check("d_rst_wait_rdata", m0_rdata_o, 64'd0);
    step(); rst = 1'b0; slv_gnt = 1'b0; slv_rvalid = 1'b0;
    @(negedge clk);
    check("d_rst_tie_m0", {slv_req_o, slv_addr_o}, {31'd0, 1'b1, 32'h50});
    check("d_rst_no_stale", {m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o}, 64'd0);
    step(); slv_gnt = 1'b1;
    @(negedge clk);
    check("d_rst_gnt", {m0_gnt_o, m1_gnt_o}, 64'b10);
    step(); slv_gnt = 1'b0; mreq[0] = 1'b0; mreq[1] = 1'b0;

    // Both masters requesting continuously from reset.
    step(); rst = 1'b1;
    step(); rst = 1'b0; mreq[0] = 1'b1; mreq[1] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      slv_gnt = (k % 2 == 1);
      @(negedge clk);
      check("d_rr_m0_gnt", m0_gnt_o, {63'd0, k % 4 == 1});
      check("d_rr_m1_gnt", m1_gnt_o, {63'd0, k % 4 == 3});
      step();
    end
    mreq[0] = 1'b0; mreq[1] = 1'b0; slv_gnt = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;

    // Randomized traffic; the negedge model checks every cycle.
    new_issue = 1'b0;
    repeat (4000) begin
      step();
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 2; i++) begin
        if (mreq[i]) begin
          if (got_g[i]) begin
            if ($urandom_range(0, 2) == 0) mreq[i] = 1'b0;
            maddr[i] = $urandom; mwdata[i] = $urandom; mwe[i] = $urandom_range(0, 1);
            mbe[i] = 4'($urandom_range(0, 15));
          end else if (m_busy && m_owner != i && $urandom_range(0, 7) == 0) begin
            maddr[i] = $urandom;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          mreq[i] = 1'b1;
          maddr[i] = $urandom; mwdata[i] = $urandom; mwe[i] = $urandom_range(0, 1);
          mbe[i] = 4'($urandom_range(0, 15));
        end
      end
      if (new_issue) begin
        new_issue = 1'b0;
        mem_age   = 0;
        case ($urandom_range(0, 7))
          4:       mem_delay = 2;
          5:       mem_delay = 3;
          6:       mem_delay = TMO + 1;
          7:       mem_delay = 0;
          default: mem_delay = 1;
        endcase
      end
      slv_rdata = $urandom;
      if (m_busy) begin
        mem_age++;
        slv_gnt    = (mem_delay != 0) && (mem_age == mem_delay);
        slv_rvalid = slv_gnt && !m_we;
      end else begin
        slv_gnt    = ($urandom_range(0, 3) == 0);
        slv_rvalid = ($urandom_range(0, 3) == 0);
      end
    end
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
